// File: rtl/fetch_addr_seq.sv
// rtl/fetch_addr_seq.sv - instruction-fetch PC sequencer with imem req/ack and jump redirect
// Optional misaligned register-jump trap: define FETCH_MISALIGN_TRAP_EN.
module fetch_addr_seq #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            jmp_valid,
    input  logic [25:0]     jmp_idx,
    input  logic            jr_valid,
    input  logic [PC_W-1:0] jr_addr,
    output logic            imem_req,
    output logic [PC_W-3:0] imem_waddr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [PC_W-1:0] instr_pc,
    output logic [PC_W-1:0] pc,
    output logic            misalign_err
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, ERR} state_t;

    state_t          state;
    logic [PC_W-1:0] jmp_target;
    logic [PC_W-1:0] jr_target;
    logic            redirect;
    logic            jr_bad;

    // Jump region bits come from the current PC, not from the target.
    always_comb begin
        jmp_target        = pc;
        jmp_target[27:0]  = {jmp_idx, 2'b00};
        jr_target         = jr_addr;
        jr_target[1:0]    = 2'b00;
    end

    assign redirect   = (state != ERR) && (jr_valid || jmp_valid);
    assign imem_waddr = pc[PC_W-1:2];

`ifdef FETCH_MISALIGN_TRAP_EN
    assign jr_bad       = jr_valid && (jr_addr[1:0] != 2'b00);
    assign misalign_err = (state == ERR);
`else
    assign jr_bad       = 1'b0;
    assign misalign_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else if (redirect) begin
            // Any outstanding request or held instruction is abandoned.
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            if (jr_bad) begin
                pc    <= jr_addr;
                state <= ERR;
            end else begin
                pc    <= jr_valid ? jr_target : jmp_target;
                state <= IDLE;
            end
        end else begin
            case (state)
                IDLE: begin
                    state       <= REQ;
                    imem_req    <= 1'b1;
                    instr_valid <= 1'b0;
                end
                REQ: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        pc          <= pc + PC_W'(4);
                        if (stall) begin
                            state    <= HOLD;
                            imem_req <= 1'b0;
                        end
                    end else begin
                        instr_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        state       <= REQ;
                        imem_req    <= 1'b1;
                        instr_valid <= 1'b0;
                    end
                end
                default: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
